// File: rtl/imem_loader.sv
// imem_loader: fills the instruction memory at boot from a byte stream.
// The stream is a one-byte word-count header N followed by N little-endian
// 32-bit instruction words. Each assembled word is written with a one-cycle
// strobe at byte addresses 0, 4, 8, ... The CPU stays in reset until a load
// completes successfully.
//
// Ports:
//   clk_i        system clock, rising edge
//   reset_i      asynchronous active-high reset
//   start_i      one-cycle pulse starting a load (honoured in IDLE/DONE/ERR)
//   in_valid_i   stream byte available on in_data_i
//   in_data_i    stream byte
//   in_ready_o   loader accepts in_data_i this cycle
//   we_o         instruction-memory write strobe, one cycle per word
//   waddr_o      word-aligned byte address of the write
//   wdata_o      instruction word to write
//   cpu_reset_o  processor reset, low only in DONE
//   busy_o       load in progress (HDR, BYTES, WRITE)
//   done_o       load completed
//   err_o        header count exceeded DEPTH
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | after reset, waiting for start
// HDR   | waiting for the word-count header byte
// BYTES | collecting the four bytes of the current word
// WRITE | one-cycle write strobe of the assembled word
// DONE  | load complete, CPU released from reset
// ERR   | header count too large, CPU held in reset

module imem_loader #(
  parameter int DEPTH = 64,
  parameter int CW    = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        in_valid_i,
  input  logic [7:0]  in_data_i,
  output logic        in_ready_o,
  output logic        we_o,
  output logic [31:0] waddr_o,
  output logic [31:0] wdata_o,
  output logic        cpu_reset_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    BYTES = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   n_q, n_d;
  logic [CW-1:0]   word_idx_q, word_idx_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [31:0]     asm_q, asm_d;
  logic [31:0]     waddr_q, waddr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            in_ready_q, we_q, cpu_reset_q, busy_q, done_q, err_q;
  logic            in_ready_d, we_d, cpu_reset_d, busy_d, done_d, err_d;
  logic            xfer;
  logic [CW-1:0]   hdr;

  // in_ready_q is a pure function of the registered state, so the handshake
  // has no combinational path from in_valid_i to in_ready_o.
  assign xfer = in_valid_i && in_ready_q;
  assign hdr  = CW'(in_data_i);

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;

    case (state_q)
      IDLE: if (start_i) state_d = HDR;
      HDR: begin
        if (xfer) begin
          if (hdr == '0) begin
            state_d = DONE;
          end else if (hdr > CW'(DEPTH)) begin
            state_d = ERR;
          end else begin
            n_d        = hdr;
            word_idx_d = '0;
            byte_cnt_d = '0;
            state_d    = BYTES;
          end
        end
      end
      BYTES: begin
        if (xfer) begin
          asm_d[{byte_cnt_q, 3'b000} +: 8] = in_data_i;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        if (word_idx_q + CW'(1) == n_q) begin
          state_d = DONE;
        end else begin
          word_idx_d = word_idx_q + CW'(1);
          byte_cnt_d = '0;
          state_d    = BYTES;
        end
      end
      DONE, ERR: if (start_i) state_d = HDR;
      default: state_d = IDLE;
    endcase

    // Address and data are captured on entry to WRITE and then held.
    we_d = (state_d == WRITE);
    if (we_d) begin
      waddr_d = {{(30-CW){1'b0}}, word_idx_q, 2'b00};
      wdata_d = asm_d;
    end

    in_ready_d  = (state_d == HDR) || (state_d == BYTES);
    busy_d      = (state_d == HDR) || (state_d == BYTES) || (state_d == WRITE);
    cpu_reset_d = (state_d != DONE);
    done_d      = (state_d == DONE);
    err_d       = (state_d == ERR);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      n_q         <= '0;
      word_idx_q  <= '0;
      byte_cnt_q  <= '0;
      asm_q       <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      in_ready_q  <= 1'b0;
      we_q        <= 1'b0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      word_idx_q  <= word_idx_d;
      byte_cnt_q  <= byte_cnt_d;
      asm_q       <= asm_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      in_ready_q  <= in_ready_d;
      we_q        <= we_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign we_o        = we_q;
  assign waddr_o     = waddr_q;
  assign wdata_o     = wdata_q;
  assign cpu_reset_o = cpu_reset_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: scoreboard of expected memory writes filled by
// a stream-level reference model, drained by an independent write monitor.

module tb_imem_loader;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, we, cpu_reset, busy, done, err;
  logic [31:0] waddr, wdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int we_cnt = 0;
  wr_t exp_q[$];
  int  we_cyc[$];

  imem_loader #(.DEPTH(64), .CW(8)) dut (
    .clk_i(clk), .reset_i(rst), .start_i(start),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
    .we_o(we), .waddr_o(waddr), .wdata_o(wdata),
    .cpu_reset_o(cpu_reset), .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe is matched against the next expected write.
  always @(negedge clk) begin
    if (!rst && we) begin
      we_cnt++;
      we_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_we", waddr, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("waddr", waddr, e.addr);
        check("wdata", wdata, e.data);
      end
    end
  end

  // Reference model: header N, then N little-endian words. Only words whose
  // four bytes are all present are expected. Returns 1=done, 2=err.
  function automatic int model(input bq_t b);
    int n;
    wr_t w;
    n = b[0];
    if (n == 0) return 1;
    if (n > 64) return 2;
    for (int k = 0; k < n; k++) begin
      if (1 + 4*k + 3 < b.size()) begin
        w.addr = 32'(4*k);
        w.data = {b[1+4*k+3], b[1+4*k+2], b[1+4*k+1], b[1+4*k]};
        exp_q.push_back(w);
      end
    end
    return 1;
  endfunction

  function automatic bq_t make_stream(input int n);
    bq_t b;
    b.push_back(8'(n));
    for (int i = 0; i < 4*n; i++) b.push_back(8'($urandom_range(255)));
    return b;
  endfunction

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Entered and left on a negedge; ready is sampled there since it is registered.
  task automatic send(input bq_t b, input int gap_pct);
    foreach (b[i]) begin
      bit acc;
      int guard;
      acc = 1'b0;
      guard = 0;
      while (!acc) begin
        bit take;
        if ($urandom_range(99) < gap_pct) in_valid = 1'b0;
        else begin in_valid = 1'b1; in_data = b[i]; end
        take = in_valid && in_ready;
        @(posedge clk);
        acc = take;
        @(negedge clk);
        guard++;
        if (guard > 200) begin
          check("send_timeout", 32'(i), 32'hFFFF_FFFF);
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_final(input int kind, input string tag);
    int guard;
    guard = 0;
    while (!(done || err) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_done"}, 32'(done), 32'(kind == 1));
    check({tag, "_err"}, 32'(err), 32'(kind == 2));
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(kind != 1));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_load(input bq_t b, input int gap_pct, input string tag);
    int kind;
    kind = model(b);
    pulse_start();
    check({tag, "_busy_on_start"}, 32'(busy), 32'd1);
    send(b, gap_pct);
    wait_final(kind, tag);
  endtask

  initial begin
    bq_t b;
    int k0, w0;

    // Reset and idle.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_waddr", waddr, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Directed 3-word load, gapless; strobes 5 cycles apart.
    b = '{8'h03, 8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00,
          8'h93, 8'h83, 8'h71, 8'hFF};
    we_cyc.delete();
    run_load(b, 0, "dir3");
    check("dir3_we_count", 32'(we_cyc.size()), 32'd3);
    if (we_cyc.size() == 3) begin
      check("dir3_gap01", 32'(we_cyc[1] - we_cyc[0]), 32'd5);
      check("dir3_gap12", 32'(we_cyc[2] - we_cyc[1]), 32'd5);
    end

    // Zero header: done in the cycle after the header, no writes.
    w0 = we_cnt;
    void'(model('{8'h00}));
    pulse_start();
    send('{8'h00}, 0);
    check("zero_done_next", 32'(done), 32'd1);
    check("zero_cpu_reset", 32'(cpu_reset), 32'd0);
    check("zero_no_we", 32'(we_cnt - w0), 32'd0);

    // Oversized header, then recovery with a 1-word load.
    w0 = we_cnt;
    run_load('{8'h41}, 0, "over");
    check("over_no_we", 32'(we_cnt - w0), 32'd0);
    @(negedge clk);
    check("over_in_ready", 32'(in_ready), 32'd0);
    b = make_stream(1);
    void'(model(b));
    pulse_start();
    check("recover_err_clear", 32'(err), 32'd0);
    send(b, 0);
    wait_final(1, "recover");

    // Random gaps with a start pulse injected mid-stream.
    b = make_stream(2);
    w0 = we_cnt;
    void'(model(b));
    pulse_start();
    fork
      send(b, 40);
      begin
        repeat (6) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    wait_final(1, "mid");
    check("mid_we_count", 32'(we_cnt - w0), 32'd2);

    // Reset after 6 bytes of a 4-word load: only word 0 was written.
    b = make_stream(4);
    begin
      bq_t part;
      for (int i = 0; i < 6; i++) part.push_back(b[i]);
      void'(model(part));
      pulse_start();
      send(part, 0);
    end
    #2 rst = 1'b1;
    #1;
    check("mrst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_in_ready", 32'(in_ready), 32'd0);
    check("mrst_we", 32'(we), 32'd0);
    check("mrst_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_load(make_stream(4), 30, "post_rst");

    // Random loads, including the largest legal count.
    for (int t = 0; t < 4; t++) begin
      k0 = $urandom_range(1, 6);
      run_load(make_stream(k0), $urandom_range(0, 50), "rand");
    end
    run_load(make_stream(64), 10, "max");
    run_load('{8'hFF}, 0, "hdr_ff");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
